// File: rtl/cl_result_packer_pkg.sv
// Shared types and helpers for the cache-line result packer: FSM states,
// slot count per line and the DATA_WIDTH -> RESULT_WIDTH extension.
package cl_pack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  // Widest slot the extend helper supports; callers cast the result down.
  localparam int EXT_MAX_W = 1024;

  function automatic int results_per_cl(input int cl_w, input int res_w);
    return cl_w / res_w;
  endfunction

  function automatic logic [EXT_MAX_W-1:0] extend(input logic [EXT_MAX_W-1:0] d,
                                                  input int data_w,
                                                  input bit sign_ext);
    logic [EXT_MAX_W-1:0] upper;
    upper  = {EXT_MAX_W{1'b1}} << data_w;
    extend = d & ~upper;
    if (sign_ext && (((d >> (data_w - 1)) & EXT_MAX_W'(1)) != '0)) begin
      extend = extend | upper;
    end
  endfunction

endpackage

// File: rtl/cl_result_packer_if.sv
// FIFO read side and DMA write side of the result packer; master is the packer.
interface cl_result_packer_if
  import cl_pack_pkg::*;
#(
  parameter int DATA_WIDTH    = 20,
  parameter int CL_DATA_WIDTH = 512
);

  logic                     src_empty;
  logic                     src_rd_en;
  logic [DATA_WIDTH-1:0]    src_rd_data;
  logic                     dma_full;
  logic                     dma_wr_en;
  logic [CL_DATA_WIDTH-1:0] dma_wr_data;

  modport master (
    input  src_empty, src_rd_data, dma_full,
    output src_rd_en, dma_wr_en, dma_wr_data
  );

  modport slave (
    output src_empty, src_rd_data, dma_full,
    input  src_rd_en, dma_wr_en, dma_wr_data
  );

endinterface

// File: rtl/cl_result_packer.sv
// Drains narrow results from a show-ahead FIFO, packs them LSB-first into
// cache lines and writes them to DMA; a short final line is padded.
module cl_result_packer
  import cl_pack_pkg::*;
#(
  parameter int                     CL_DATA_WIDTH = 512,
  parameter int                     RESULT_WIDTH  = 32,
  parameter int                     DATA_WIDTH    = 20,
  parameter int                     SIGN_EXTEND   = 0,
  parameter logic [RESULT_WIDTH-1:0] PAD_VALUE    = '0,
  parameter int                     COUNT_WIDTH   = 65
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic [COUNT_WIDTH-1:0] total_results,
  cl_result_packer_if.master     bus,
  output logic [COUNT_WIDTH-1:0] lines_written,
  output logic                   done
);

  localparam int RPC    = results_per_cl(CL_DATA_WIDTH, RESULT_WIDTH);
  localparam int SLOT_W = $clog2(RPC + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(RPC);

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   total_q, consumed_q, consumed_inc;
  logic [SLOT_W-1:0]        slot_q, slot_inc;
  logic                     rd_fire, wr_fire, start, repad;
  logic [RESULT_WIDTH-1:0]  ext_result;
  logic [CL_DATA_WIDTH-1:0] line_buf;

  assign slot_inc     = slot_q + SLOT_W'(1);
  assign consumed_inc = consumed_q + COUNT_WIDTH'(1);
  assign ext_result   = RESULT_WIDTH'(extend(EXT_MAX_W'(bus.src_rd_data), DATA_WIDTH,
                                             SIGN_EXTEND != 0));

  // The line leaves FILL on the read that fills the last slot or consumes the last result.
  always_comb begin
    state_d = state_q;
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          start   = 1'b1;
          state_d = (total_results == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        rd_fire = !bus.src_empty && (slot_q < SLOT_LAST) && (consumed_q < total_q);
        if (rd_fire && ((slot_inc == SLOT_LAST) || (consumed_inc == total_q))) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_fire = !bus.dma_full;
        if (wr_fire) begin
          state_d = (consumed_q == total_q) ? DONE : FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      total_q       <= '0;
      consumed_q    <= '0;
      slot_q        <= '0;
      lines_written <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        total_q       <= total_results;
        consumed_q    <= '0;
        slot_q        <= '0;
        lines_written <= '0;
      end else begin
        if (rd_fire) begin
          slot_q     <= slot_inc;
          consumed_q <= consumed_inc;
        end
        if (wr_fire) begin
          slot_q        <= '0;
          lines_written <= lines_written + COUNT_WIDTH'(1);
        end
      end
    end
  end

  // Every slot returns to the pad value at go and once its line has been accepted.
  assign repad = start | wr_fire;

  for (genvar k = 0; k < RPC; k++) begin : g_slot
    logic [RESULT_WIDTH-1:0] slot_data;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_data <= PAD_VALUE;
      end else if (repad) begin
        slot_data <= PAD_VALUE;
      end else if (rd_fire && (slot_q == SLOT_W'(k))) begin
        slot_data <= ext_result;
      end
    end
    assign line_buf[k*RESULT_WIDTH +: RESULT_WIDTH] = slot_data;
  end

  assign bus.src_rd_en   = rd_fire;
  assign bus.dma_wr_en   = wr_fire;
  assign bus.dma_wr_data = line_buf;
  assign done            = (state_q == DONE);

endmodule

// File: tb/tb_cl_result_packer.sv
// Self-checking bench for cl_result_packer: randomized FIFO/DMA traffic against
// a queue-based model of the expected cache lines.
module tb_cl_result_packer;
  import cl_pack_pkg::*;

  localparam int CLW = 512;
  localparam int RW  = 32;
  localparam int DW  = 20;
  localparam int RPC = 16;
  localparam int CW  = 65;
  localparam logic [RW-1:0] PAD = 32'hA5A5_5A5A;

  typedef logic [DW-1:0]  data_q_t[$];
  typedef logic [CLW-1:0] line_q_t[$];

  logic          clk = 1'b0;
  logic          rst, go, done;
  logic [CW-1:0] total_results, lines_written;
  logic          go2, done2;
  logic [CW-1:0] total2, lines2;

  cl_result_packer_if #(.DATA_WIDTH(DW), .CL_DATA_WIDTH(CLW)) bus ();
  cl_result_packer_if #(.DATA_WIDTH(DW), .CL_DATA_WIDTH(64))  bus2 ();

  cl_result_packer #(
    .CL_DATA_WIDTH(CLW), .RESULT_WIDTH(RW), .DATA_WIDTH(DW),
    .SIGN_EXTEND(0), .PAD_VALUE(PAD), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .total_results(total_results),
    .bus(bus), .lines_written(lines_written), .done(done)
  );

  cl_result_packer #(
    .CL_DATA_WIDTH(64), .RESULT_WIDTH(RW), .DATA_WIDTH(DW),
    .SIGN_EXTEND(1), .PAD_VALUE(32'h0), .COUNT_WIDTH(CW)
  ) dut_sx (
    .clk(clk), .rst(rst), .go(go2), .total_results(total2),
    .bus(bus2), .lines_written(lines2), .done(done2)
  );

  always #5 clk = ~clk;

  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  data_q_t fifo_q;
  line_q_t wr_log;
  int      wr_cyc[$];
  int      rd_count = 0;
  int      first_rd_cyc = -1;
  int      stall_pct = 0;
  int      full_pct = 0;
  bit      full_rand = 0;

  // FIFO and DMA sink model: sample strobes at the edge, update inputs 1 time unit later.
  initial begin
    bit pop;
    bus.src_empty   = 1'b1;
    bus.src_rd_data = '0;
    bus.dma_full    = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      pop = bus.src_rd_en;
      if (bus.src_rd_en) begin
        rd_count++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (bus.dma_wr_en) begin
        wr_log.push_back(bus.dma_wr_data);
        wr_cyc.push_back(cyc);
      end
      #1;
      if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      bus.src_empty   = (fifo_q.size() == 0) || (int'($urandom_range(99)) < stall_pct);
      bus.src_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      if (full_rand) bus.dma_full = int'($urandom_range(99)) < full_pct;
    end
  end

  function automatic logic [RW-1:0] ref_ext(input logic [DW-1:0] d, input bit sx);
    logic [RW-1:0] v;
    v = RW'(d);
    if (sx && v >= (32'd1 << (DW - 1))) v = v | ~((32'd1 << DW) - 32'd1);
    return v;
  endfunction

  function automatic void build_lines(input data_q_t d, input int total, input bit sx,
                                      output line_q_t lines);
    logic [CLW-1:0] ln;
    lines = {};
    for (int l = 0; l < (total + RPC - 1) / RPC; l++) begin
      ln = '0;
      for (int k = 0; k < RPC; k++) begin
        ln[k*RW +: RW] = (l * RPC + k < total) ? ref_ext(d[l*RPC+k], sx) : PAD;
      end
      lines.push_back(ln);
    end
  endfunction

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    rd_count     = 0;
    first_rd_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_random(input int n, output data_q_t d);
    d = {};
    for (int i = 0; i < n; i++) d.push_back(DW'($urandom));
    fifo_q = d;
  endtask

  task automatic pulse_go(input logic [CW-1:0] t, output int go_cyc);
    @(posedge clk);
    #1;
    total_results = t;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    go_cyc = cyc;
  endtask

  task automatic run_and_wait(input logic [CW-1:0] t, input int budget, output bit timed_out,
                              output int go_cyc, output int done_cyc);
    pulse_go(t, go_cyc);
    timed_out = 1'b1;
    done_cyc  = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        done_cyc  = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.src_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_en got=%b exp=0", bus.src_rd_en); end
    checks++; if (bus.dma_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en got=%b exp=0", bus.dma_wr_en); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (lines_written !== '0) begin failures++; $display("[TB] FAIL reset_lines got=%0d exp=0", lines_written); end
    checks++; if (bus.dma_wr_data !== {RPC{PAD}}) begin failures++; $display("[TB] FAIL reset_wr_data got=%h exp=all pad", bus.dma_wr_data[63:0]); end
    rst = 1'b0;
  endtask

  task automatic test_full_lines();
    data_q_t d;
    line_q_t exp;
    bit      to;
    int      go_cyc, done_cyc;
    clear_logs();
    d = {};
    for (int i = 1; i <= 32; i++) d.push_back(DW'(i));
    fifo_q = d;
    stall_pct = 0;
    run_and_wait(32, 200, to, go_cyc, done_cyc);
    build_lines(d, 32, 1'b0, exp);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL full_timeout got=timeout exp=done"); end
    checks++; if (wr_log.size() != 2) begin failures++; $display("[TB] FAIL full_write_count got=%0d exp=2", wr_log.size()); end
    for (int l = 0; l < 2 && l < wr_log.size(); l++) begin
      checks++; if (wr_log[l] !== exp[l]) begin failures++; $display("[TB] FAIL full_line%0d got=%h exp=%h", l, wr_log[l][127:0], exp[l][127:0]); end
    end
    checks++; if (lines_written !== CW'(2)) begin failures++; $display("[TB] FAIL full_lines_written got=%0d exp=2", lines_written); end
    checks++; if (first_rd_cyc != go_cyc + 1) begin failures++; $display("[TB] FAIL go_to_rd got=%0d exp=%0d", first_rd_cyc, go_cyc + 1); end
    if (wr_cyc.size() == 2) begin
      checks++; if (wr_cyc[0] != go_cyc + 17) begin failures++; $display("[TB] FAIL first_write_cyc got=%0d exp=%0d", wr_cyc[0], go_cyc + 17); end
      checks++; if (wr_cyc[1] - wr_cyc[0] != 17) begin failures++; $display("[TB] FAIL line_spacing got=%0d exp=17", wr_cyc[1] - wr_cyc[0]); end
      checks++; if (done_cyc != wr_cyc[1]) begin failures++; $display("[TB] FAIL full_done_latency got=%0d exp=%0d", done_cyc, wr_cyc[1]); end
    end
  endtask

  task automatic test_partial();
    data_q_t d;
    line_q_t exp;
    bit      to;
    int      go_cyc, done_cyc;
    clear_logs();
    fill_random(20, d);
    stall_pct = 30;
    run_and_wait(20, 500, to, go_cyc, done_cyc);
    stall_pct = 0;
    build_lines(d, 20, 1'b0, exp);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL partial_timeout got=timeout exp=done"); end
    checks++; if (wr_log.size() != 2) begin failures++; $display("[TB] FAIL partial_write_count got=%0d exp=2", wr_log.size()); end
    for (int l = 0; l < 2 && l < wr_log.size(); l++) begin
      checks++; if (wr_log[l] !== exp[l]) begin failures++; $display("[TB] FAIL partial_line%0d got=%h exp=%h", l, wr_log[l][255:0], exp[l][255:0]); end
    end
    checks++; if (lines_written !== CW'(2)) begin failures++; $display("[TB] FAIL partial_lines_written got=%0d exp=2", lines_written); end
    if (wr_cyc.size() == 2) begin
      checks++; if (done_cyc != wr_cyc[1]) begin failures++; $display("[TB] FAIL partial_done_latency got=%0d exp=%0d", done_cyc, wr_cyc[1]); end
    end
  endtask

  task automatic test_random();
    data_q_t d;
    line_q_t exp;
    bit      to;
    int      go_cyc, done_cyc, total;
    for (int it = 0; it < 5; it++) begin
      clear_logs();
      total = int'($urandom_range(1, 50));
      fill_random(total, d);
      stall_pct = 25;
      full_pct  = 40;
      full_rand = 1'b1;
      run_and_wait(CW'(total), 2000, to, go_cyc, done_cyc);
      build_lines(d, total, 1'b0, exp);
      checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL rand%0d_timeout got=timeout exp=done", it); end
      checks++; if (wr_log.size() != exp.size()) begin failures++; $display("[TB] FAIL rand%0d_write_count got=%0d exp=%0d", it, wr_log.size(), exp.size()); end
      for (int l = 0; l < exp.size() && l < wr_log.size(); l++) begin
        checks++; if (wr_log[l] !== exp[l]) begin failures++; $display("[TB] FAIL rand%0d_line%0d got=%h exp=%h", it, l, wr_log[l][127:0], exp[l][127:0]); end
      end
      checks++; if (lines_written !== CW'(exp.size())) begin failures++; $display("[TB] FAIL rand%0d_lines_written got=%0d exp=%0d", it, lines_written, exp.size()); end
      if (wr_cyc.size() > 0) begin
        checks++; if (done_cyc != wr_cyc[wr_cyc.size()-1]) begin failures++; $display("[TB] FAIL rand%0d_done_latency got=%0d exp=%0d", it, done_cyc, wr_cyc[wr_cyc.size()-1]); end
      end
    end
    full_rand = 1'b0;
    stall_pct = 0;
    @(posedge clk);
    #2;
    bus.dma_full = 1'b0;
  endtask

  task automatic test_backpressure();
    data_q_t        d;
    line_q_t        exp;
    logic [CLW-1:0] snap;
    int             go_cyc, drop_cyc;
    bit             reached;
    clear_logs();
    fill_random(32, d);
    build_lines(d, 32, 1'b0, exp);
    bus.dma_full = 1'b1;
    pulse_go(32, go_cyc);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_count == 16) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin failures++; $display("[TB] FAIL bp_fill_timeout got=%0d reads exp=16", rd_count); end
    snap = bus.dma_wr_data;
    checks++; if (snap !== exp[0]) begin failures++; $display("[TB] FAIL bp_held_line got=%h exp=%h", snap[127:0], exp[0][127:0]); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.dma_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL bp_wr_en cyc%0d got=%b exp=0", i, bus.dma_wr_en); end
      checks++; if (bus.src_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL bp_rd_en cyc%0d got=%b exp=0", i, bus.src_rd_en); end
      checks++; if (bus.dma_wr_data !== snap) begin failures++; $display("[TB] FAIL bp_data_stable cyc%0d got=%h exp=%h", i, bus.dma_wr_data[127:0], snap[127:0]); end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.dma_full = 1'b0;
    drop_cyc = cyc;
    @(negedge clk);
    checks++; if (bus.dma_wr_en !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_wr_en got=%b exp=1", bus.dma_wr_en); end
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    checks++; if (wr_log.size() != 2) begin failures++; $display("[TB] FAIL bp_write_count got=%0d exp=2", wr_log.size()); end
    if (wr_log.size() == 2) begin
      checks++; if (wr_cyc[0] != drop_cyc + 1) begin failures++; $display("[TB] FAIL bp_write_cyc got=%0d exp=%0d", wr_cyc[0], drop_cyc + 1); end
      checks++; if (wr_log[1] !== exp[1]) begin failures++; $display("[TB] FAIL bp_line1 got=%h exp=%h", wr_log[1][127:0], exp[1][127:0]); end
    end
  endtask

  task automatic test_zero();
    data_q_t d;
    bit      to;
    int      go_cyc, done_cyc;
    do_reset();
    clear_logs();
    fill_random(4, d);
    run_and_wait(0, 10, to, go_cyc, done_cyc);
    checks++; if (to !== 1'b0 || done_cyc != go_cyc) begin failures++; $display("[TB] FAIL zero_done got_cyc=%0d exp_cyc=%0d", done_cyc, go_cyc); end
    repeat (5) @(negedge clk);
    checks++; if (rd_count != 0) begin failures++; $display("[TB] FAIL zero_reads got=%0d exp=0", rd_count); end
    checks++; if (wr_log.size() != 0) begin failures++; $display("[TB] FAIL zero_writes got=%0d exp=0", wr_log.size()); end
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL zero_done_held got=%b exp=1", done); end
    fifo_q.delete();
  endtask

  task automatic test_extend();
    data_q_t        d;
    line_q_t        exp;
    bit             to;
    int             go_cyc, done_cyc;
    logic [63:0]    got;
    bit             seen;
    clear_logs();
    d = {20'hFFFFF};
    fifo_q = d;
    run_and_wait(1, 100, to, go_cyc, done_cyc);
    build_lines(d, 1, 1'b0, exp);
    checks++; if (wr_log.size() != 1) begin failures++; $display("[TB] FAIL zext_write_count got=%0d exp=1", wr_log.size()); end
    if (wr_log.size() == 1) begin
      checks++; if (wr_log[0][31:0] !== 32'h000FFFFF) begin failures++; $display("[TB] FAIL zext_slot0 got=%h exp=000fffff", wr_log[0][31:0]); end
      checks++; if (wr_log[0] !== exp[0]) begin failures++; $display("[TB] FAIL zext_line got=%h exp=%h", wr_log[0][127:0], exp[0][127:0]); end
    end
    for (int p = 0; p < 2; p++) begin
      logic [DW-1:0] val;
      val = (p == 0) ? 20'hFFFFF : 20'h7FFFF;
      bus2.src_rd_data = val;
      @(posedge clk);
      #1;
      total2 = 2;
      go2 = 1'b1;
      @(posedge clk);
      #1;
      go2 = 1'b0;
      seen = 1'b0;
      got = '0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk);
        if (bus2.dma_wr_en) begin seen = 1'b1; got = bus2.dma_wr_data; end
      end
      @(negedge clk);
      checks++; if (!seen || got !== {ref_ext(val, 1'b1), ref_ext(val, 1'b1)}) begin failures++; $display("[TB] FAIL sext%0d_line got=%h exp=%h", p, got, {ref_ext(val, 1'b1), ref_ext(val, 1'b1)}); end
      checks++; if (done2 !== 1'b1 || lines2 !== CW'(1)) begin failures++; $display("[TB] FAIL sext%0d_done got=%b/%0d exp=1/1", p, done2, lines2); end
    end
    checks++; if (ref_ext(20'hFFFFF, 1'b1) !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL sext_model got=%h exp=ffffffff", ref_ext(20'hFFFFF, 1'b1)); end
  endtask

  task automatic test_reset_mid();
    data_q_t d;
    line_q_t exp;
    bit      to, reached;
    int      go_cyc, done_cyc;
    clear_logs();
    fill_random(16, d);
    pulse_go(16, go_cyc);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_count == 5) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin failures++; $display("[TB] FAIL rmid_reads got=%0d exp=5", rd_count); end
    rst = 1'b1;
    #1;
    checks++; if (bus.src_rd_en !== 1'b0 || bus.dma_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL rmid_strobes got=%b%b exp=00", bus.src_rd_en, bus.dma_wr_en); end
    checks++; if (done !== 1'b0 || lines_written !== '0) begin failures++; $display("[TB] FAIL rmid_status got=%b/%0d exp=0/0", done, lines_written); end
    checks++; if (bus.dma_wr_data !== {RPC{PAD}}) begin failures++; $display("[TB] FAIL rmid_wr_data got=%h exp=all pad", bus.dma_wr_data[127:0]); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (wr_log.size() != 0) begin failures++; $display("[TB] FAIL rmid_no_write got=%0d exp=0", wr_log.size()); end
    clear_logs();
    fill_random(16, d);
    run_and_wait(16, 200, to, go_cyc, done_cyc);
    build_lines(d, 16, 1'b0, exp);
    checks++; if (to !== 1'b0 || wr_log.size() != 1) begin failures++; $display("[TB] FAIL rmid_restart_count got=%0d exp=1", wr_log.size()); end
    if (wr_log.size() == 1) begin
      checks++; if (wr_log[0] !== exp[0]) begin failures++; $display("[TB] FAIL rmid_restart_line got=%h exp=%h", wr_log[0][127:0], exp[0][127:0]); end
    end
    checks++; if (lines_written !== CW'(1)) begin failures++; $display("[TB] FAIL rmid_lines_written got=%0d exp=1", lines_written); end
  endtask

  initial begin
    rst = 1'b1;
    go = 1'b0;
    total_results = '0;
    go2 = 1'b0;
    total2 = '0;
    bus2.src_empty = 1'b0;
    bus2.src_rd_data = '0;
    bus2.dma_full = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_full_lines();
    test_partial();
    test_random();
    test_backpressure();
    test_zero();
    test_extend();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cl_result_packer.md
# cl_result_packer

Parametrised output packer that drains narrow results from a show-ahead absorption FIFO and assembles them into cache lines for the DMA write channel. It sits between a sample/result pipeline and the DMA write port. Result width, field width and extension mode are configurable. A programmable result count terminates the stream, and a final partial cache line is flushed padded, so software no longer has to supply a multiple of RESULTS_PER_CL results.

## Interface
Parameters:
- CL_DATA_WIDTH, 512, cache-line width in bits.
- RESULT_WIDTH, 32, slot width in the cache line; must divide CL_DATA_WIDTH.
- DATA_WIDTH, 20, width of each FIFO result; must be ≤ RESULT_WIDTH.
- SIGN_EXTEND, 0, 1 = sign-extend DATA_WIDTH to RESULT_WIDTH; 0 = zero-extend.
- PAD_VALUE, '0, RESULT_WIDTH-bit value written into unfilled slots.
- COUNT_WIDTH, 65, width of the result and line counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- go  in  1  single-cycle start pulse; samples total_results.
- total_results  in  COUNT_WIDTH  number of results to consume.
- src_empty  in  1  FIFO empty.
- src_rd_en  out  1  FIFO read; src_rd_data is valid in the same cycle (show-ahead).
- src_rd_data  in  DATA_WIDTH  FIFO head.
- dma_full  in  1  DMA write channel full.
- dma_wr_en  out  1  cache-line write strobe.
- dma_wr_data  out  CL_DATA_WIDTH  packed cache line.
- lines_written  out  COUNT_WIDTH  cache lines accepted since go.
- done  out  1  stream complete; level, held until next go or rst.

## Operation
- RESULTS_PER_CL = CL_DATA_WIDTH/RESULT_WIDTH.
- Slot k occupies bits [k*RESULT_WIDTH +: RESULT_WIDTH]. The first result of a line goes in slot 0 (LSB first).
- The buffer is set to PAD_VALUE in every slot at go and after every accepted write.
- States: IDLE, FILL, WRITE, DONE.
- **IDLE:** on go, latch total_results and clear consumed, slot and lines_written.
  - If total_results==0, next state is DONE.
  - Otherwise, next state is FILL.
- **FILL:** src_rd_en = !src_empty && slot<RESULTS_PER_CL && consumed<total.
  - On each read, write the extended result into the current slot, then increment slot and consumed.
  - Go to WRITE when slot reaches RESULTS_PER_CL, or when consumed reaches total with slot>0. The test uses next-state values, so the transition happens in the cycle after the last read.
- **WRITE:** dma_wr_en = !dma_full. No FIFO reads occur in WRITE.
  - On write: lines_written++, slot cleared, buffer re-padded.
  - Next state is DONE if consumed==total, else FILL.
- **DONE:** done=1; go restarts exactly as from IDLE and clears done in the next cycle.
- go outside IDLE/DONE is ignored.
- Total lines written = ceil(total_results/RESULTS_PER_CL).
- Extension: SIGN_EXTEND replicates bit DATA_WIDTH-1; otherwise the upper bits are zero. When DATA_WIDTH==RESULT_WIDTH, data passes through unchanged.

## Timing
- Reset values:
  - state IDLE;
  - src_rd_en 0, dma_wr_en 0, done 0, lines_written 0;
  - dma_wr_data all slots PAD_VALUE.
- src_rd_en and dma_wr_en are combinational from registered state and the inputs. dma_wr_data is a register.
- Latency:
  - last slot read to dma_wr_en: 1 cycle (dma_full low);
  - go to first src_rd_en: 1 cycle;
  - final write to done: 1 cycle.
- Throughput: one result per cycle while FILL; one bubble cycle per line.
- dma_full high in WRITE: dma_wr_en stays 0, dma_wr_data is held stable, and the state stays in WRITE.
- src_empty high in FILL: stall with no slot advance; a partial line is not written until the total is reached.
- Reset mid-operation discards the partial line and returns all outputs to reset values; no write is issued.

## Structure
- Shared package cl_pack_pkg holds:
  - the state enum typedef;
  - an extend function (DATA_WIDTH to RESULT_WIDTH, sign/zero);
  - the RESULTS_PER_CL helper.
- CL_DATA_WIDTH defaults from $size(t_ccip_clData) at the instantiating AFU.
- The block is a single module with no sub-modules. The slot-indexed buffer write is an inline generate loop.

## Test plan
- total=32, RESULT_WIDTH=32, DATA_WIDTH=20, FIFO holds 1..32 → 2 writes; line 0 slot k = k+1, line 1 slot k = k+17; lines_written=2; done set.
- total=20 → 2 writes; second line slots 0–3 = 17..20, slots 4–15 = PAD_VALUE; done 1 cycle after the second write.
- dma_full held high 10 cycles while in WRITE → dma_wr_en 0, data stable, src_rd_en 0; the write occurs in the cycle full drops.
- SIGN_EXTEND=1, input 20'hFFFFF → slot 32'hFFFFFFFF; SIGN_EXTEND=0 → 32'h000FFFFF.
- total=0 → done asserted 1 cycle after go; no src_rd_en or dma_wr_en ever.
- rst asserted after 5 of 16 results → all outputs return to reset values; a following go with total=16 produces one correct line.
